// File: rtl/trig_pulse_seq.sv
// trig_pulse_seq
//
// Programmable trigger-to-pulse-train sequencer. An accepted trigger latches
// the delay/width/gap/repeat configuration, waits `delay` cycles, then emits
// max(repeat_n,1) pulses, each max(width,1) cycles high, separated by
// max(gap,1) low cycles. A one-cycle `done` strobe marks normal completion.
// A trigger arriving while a sequence is active (or on the done cycle) is
// ignored and raises the sticky `overrun` flag.
//
// Ports:
//   clk        system clock, all state updates on rising edge
//   rst        asynchronous active-high reset
//   trigger    single-cycle start request
//   abort      synchronous termination of a running sequence
//   clr_ovr    synchronous clear of the overrun flag
//   delay      cycles from trigger to first pulse        (CW bits)
//   width      pulse high time in cycles                 (CW bits)
//   gap        low time between pulses in cycles         (CW bits)
//   repeat_n   pulses per sequence                       (NW bits)
//   pulse_out  registered pulse train
//   busy       high while a sequence is in progress
//   done       one-cycle completion strobe
//   overrun    sticky "trigger while busy" flag

module trig_pulse_seq #(
    parameter int CW = 16,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          trigger,
    input  logic          abort,
    input  logic          clr_ovr,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] width,
    input  logic [CW-1:0] gap,
    input  logic [NW-1:0] repeat_n,
    output logic          pulse_out,
    output logic          busy,
    output logic          done,
    output logic          overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] width_r;
    logic [CW-1:0] gap_r;
    logic [NW-1:0] rem;

    logic [CW-1:0] width_load;
    logic [CW-1:0] gap_load;
    logic          ovr_event;

    // Phase counters count down to zero, so a phase of N cycles loads N-1.
    // A zero setting is treated as one cycle, which also keeps the load
    // value from wrapping.
    always_comb begin
        width_load = '0;
        gap_load   = '0;
        if (width_r != '0) width_load = width_r - CW'(1);
        if (gap_r != '0)   gap_load   = gap_r - CW'(1);
    end

    // The done cycle still counts as "not ready": a trigger there is refused
    // and flagged, so a new sequence can never start on the strobe cycle.
    assign ovr_event = trigger && ((state != IDLE) || done);

    // Main sequencer: state, counters, latched config and all outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            width_r   <= '0;
            gap_r     <= '0;
            rem       <= '0;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            done <= 1'b0;

            // Set has priority over clear so a same-cycle event is not lost.
            if (ovr_event) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            if (state == IDLE) begin
                if (trigger && !abort && !done) begin
                    state   <= DELAY;
                    busy    <= 1'b1;
                    cnt     <= delay;
                    width_r <= width;
                    gap_r   <= gap;
                    rem     <= (repeat_n == '0) ? NW'(1) : repeat_n;
                end
            end else if (abort) begin
                // Abort beats everything else, including normal completion.
                state     <= IDLE;
                busy      <= 1'b0;
                pulse_out <= 1'b0;
                cnt       <= '0;
                rem       <= '0;
            end else begin
                case (state)
                    DELAY: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            state     <= HIGH;
                            pulse_out <= 1'b1;
                            cnt       <= width_load;
                        end
                    end
                    HIGH: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else if (rem == NW'(1)) begin
                            // Last pulse falls: no trailing gap.
                            state     <= IDLE;
                            pulse_out <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            rem       <= '0;
                        end else begin
                            state     <= GAP;
                            pulse_out <= 1'b0;
                            rem       <= rem - NW'(1);
                            cnt       <= gap_load;
                        end
                    end
                    GAP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            state     <= HIGH;
                            pulse_out <= 1'b1;
                            cnt       <= width_load;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        pulse_out <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/trig_pulse_seq.md
TRIG_PULSE_SEQ -- requirements
Module: trig_pulse_seq

Interface
REQ-001 Parameter CW, default 16, width of delay/width/gap counters.
REQ-002 Parameter NW, default 8, width of repeat count.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 trigger  input  1  single-cycle start pulse from the upstream rising-edge detector (change2_2.trigger2).
REQ-006 abort  input  1  synchronous request to terminate a running sequence.
REQ-007 clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-008 delay  input  CW  cycles from trigger to first pulse, sampled on accepted trigger.
REQ-009 width  input  CW  pulse high time in cycles, sampled on accepted trigger.
REQ-010 gap  input  CW  low time between pulses in cycles, sampled on accepted trigger.
REQ-011 repeat_n  input  NW  number of pulses per sequence, sampled on accepted trigger.
REQ-012 pulse_out  output  1  registered output pulse train.
REQ-013 busy  output  1  high while a sequence is in progress.
REQ-014 done  output  1  one-cycle completion strobe.
REQ-015 overrun  output  1  sticky flag: trigger arrived while busy.

Function
REQ-016 FSM states SHALL be IDLE, DELAY, HIGH, GAP; all outputs registered.
REQ-017 In IDLE, trigger=1 and abort=0 at edge N SHALL accept: latch delay/width/gap/repeat_n, set busy=1 after edge N.
REQ-018 First pulse_out rising SHALL occur after edge N+1+delay; delay=0 gives pulse_out high after edge N+1.
REQ-019 pulse_out SHALL stay high exactly max(width,1) cycles.
REQ-020 Between consecutive pulses pulse_out SHALL be low exactly max(gap,1) cycles.
REQ-021 Sequence SHALL emit exactly max(repeat_n,1) pulses; gap not applied after last pulse.
REQ-022 At the edge where the last pulse falls, busy SHALL go 0, done SHALL be 1 for that one cycle, state SHALL return to IDLE.
REQ-023 Latched config SHALL be used for the whole sequence; input changes while busy have no effect.
REQ-024 trigger=1 while state is not IDLE (including the cycle done is asserted) SHALL be ignored and SHALL set overrun=1.
REQ-025 overrun SHALL clear on clr_ovr=1 unless a new overrun event occurs the same cycle (set wins).
REQ-026 abort=1 while busy SHALL, at the next edge, drive pulse_out=0, busy=0, state IDLE, with done=0.
REQ-027 abort=1 and trigger=1 in IDLE same cycle: abort wins, trigger ignored, overrun unchanged.
REQ-028 Counters SHALL be CW/NW bits, count down to terminal value, never wrap; all-ones values SHALL give exact 2^CW-1 cycles / 2^NW-1 pulses.

Reset
REQ-029 rst=1 SHALL immediately force state IDLE, pulse_out=0, busy=0, done=0, overrun=0, all counters and latched config to 0.
REQ-030 rst asserted mid-sequence SHALL abort without done; after release a trigger SHALL start a fresh sequence normally.
REQ-031 First accepted trigger SHALL be the one sampled on the first posedge with rst=0.

Verification
REQ-032 delay=3, width=2, gap=4, repeat_n=3, trigger at edge 10 -> pulse_out high after edges 14-15, 20-21, 26-27 (low otherwise); done=1 and busy=0 after edge 28.
REQ-033 delay=0, width=0, gap=0, repeat_n=0, trigger at edge 5 -> single 1-cycle pulse after edge 6, done after edge 7.
REQ-034 Second trigger 3 cycles after accepted trigger, and another on the done cycle -> both ignored, sequence timing unchanged, overrun=1 until clr_ovr pulse.
REQ-035 abort during second HIGH of a 3-pulse sequence -> pulse_out=0, busy=0 next edge, done never asserted; next trigger restarts with full repeat count.
REQ-036 rst asserted asynchronously mid-DELAY (between edges) -> busy, pulse_out drop without clock; overrun=0; trigger after release runs a correct sequence.
REQ-037 Config inputs changed every cycle while busy -> output timing matches values latched at trigger.
